// File: rtl/regfile_pkg.sv
// Shared defaults and index typing for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

    function automatic int aw_of(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on writeback.
// Latency: busy updates on the rising edge; async reset clears it at once.
// Backpressure: none, set and clear are accepted every cycle.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = aw_of(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [AW-1:0]    set_idx,
    input  logic             clr,
    input  logic [AW-1:0]    clr_idx,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_nxt;

    // Set is applied after clear so a newer producer keeps the register busy.
    always_comb begin
        busy_nxt = busy;
        if (clr && (clr_idx != '0))
            busy_nxt[clr_idx] = 1'b0;
        if (set && (set_idx != '0))
            busy_nxt[set_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read register file with busy scoreboard; r0 hardwired to zero.
// Latency: reads combinational, writes on the edge; REGFILE_SB_BYPASS_EN forwards wd to matching reads.
// Backpressure: none, writeback and issue are accepted every cycle.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = aw_of(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_rdy,
    output logic [NREGS-1:0]    busy
);

    logic [XLEN-1:0] mem [NREGS];
    logic            wr_hit;

    assign wr_hit = we && (wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                mem[i] <= '0;
        end else if (wr_hit) begin
            mem[wa] <= wd;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set     (iss_valid),
        .set_idx (iss_rd),
        .clr     (we),
        .clr_idx (wa),
        .busy    (busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] idx;
        logic          byp;
        assign idx = ra[i*AW +: AW];
`ifdef REGFILE_SB_BYPASS_EN
        // Reset suppresses forwarding so reads stay zero while rst is held.
        assign byp = wr_hit && (idx == wa) && !rst;
`else
        assign byp = 1'b0;
`endif
        assign rd[i*XLEN +: XLEN] = byp ? wd : ((idx == '0) ? '0 : mem[idx]);
        assign rd_rdy[i]          = byp | ~busy[idx];
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 64: register data width in bits.
REQ-002 Parameter NREGS, default 32: register count, power of two, at least 2; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2: number of read ports, at least 1.
REQ-004 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port we, input, 1: writeback enable.
REQ-007 Port wa, input, AW: writeback register index.
REQ-008 Port wd, input, XLEN: writeback data.
REQ-009 Port iss_valid, input, 1: issue of an instruction that will later write iss_rd.
REQ-010 Port iss_rd, input, AW: destination index to mark busy.
REQ-011 Port ra, input, NRD*AW: read indices; port i occupies bits [i*AW +: AW].
REQ-012 Port rd, output, NRD*XLEN: read data, one XLEN slice per port.
REQ-013 Port rd_rdy, output, NRD: per-port operand-valid flag.
REQ-014 Port busy, output, NREGS: registered scoreboard vector.

Function
REQ-015 Reads SHALL be combinational from ra to rd, with zero-cycle latency.
REQ-016 Index 0 SHALL always read 0, have rd_rdy = 1, and never be busy; writes and issues to index 0 SHALL be ignored.
REQ-017 When we = 1 and wa != 0, wd SHALL be stored in register wa at the rising edge.
REQ-018 On a rising edge with we = 1 and wa != 0, busy[wa] SHALL clear.
REQ-019 On a rising edge with iss_valid = 1 and iss_rd != 0, busy[iss_rd] SHALL set.
REQ-020 When issue and writeback target the same index in the same cycle, issue SHALL win and busy SHALL stay set, because a newer producer exists.
REQ-021 Outside the bypass case, rd_rdy[i] SHALL equal NOT busy[ra_i].
REQ-022 Multiple read ports addressing the same index SHALL return identical data and identical rd_rdy.
REQ-023 Indices SHALL use AW bits only; no out-of-range case exists.
REQ-024 The block SHALL keep no state besides the register array and busy.

Reset
REQ-025 Asserting rst SHALL immediately clear all registers to 0 and all busy bits to 0, with no clock required.
REQ-026 While rst = 1, rd SHALL read 0 and rd_rdy SHALL be all ones.
REQ-027 Reset asserted mid-operation SHALL discard pending writebacks and issues in that cycle.
REQ-028 The first write SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 The macro REGFILE_SB_BYPASS_EN SHALL select write-to-read bypass.
REQ-030 With REGFILE_SB_BYPASS_EN defined: when we = 1, wa != 0 and ra_i == wa, rd slice i SHALL equal wd in the same cycle and rd_rdy[i] SHALL be 1, even if busy[wa] = 1.
REQ-031 Without REGFILE_SB_BYPASS_EN: rd slice i SHALL return the stored (old) value until the edge, and rd_rdy[i] SHALL follow busy alone.

Structure
REQ-032 Package regfile_pkg SHALL hold the XLEN and NREGS defaults, the AW derivation and the register-index typedef.
REQ-033 The scoreboard SHALL be the sub-module regfile_scoreboard, with inputs clk, rst, set/set index and clear/clear index, and output busy; the issue-wins priority SHALL live inside it.
REQ-034 The data array and the bypass mux SHALL remain in regfile_sb.

Verification
REQ-035 Scenario, write/read: write reg5 = A5A5A5A5A5A5A5A5, then read ra0 = 5, ra1 = 0 -> rd0 = A5A5A5A5A5A5A5A5, rd1 = 0, rd_rdy = 11.
REQ-036 Scenario, same-cycle read-after-write: we = 1, wa = 7, wd = FFFFFFFFFFFFFFFF, ra0 = 7 in the same cycle -> rd0 = FFFFFFFFFFFFFFFF with bypass; without bypass, the old value 0, then FFFFFFFFFFFFFFFF next cycle.
REQ-037 Scenario, scoreboard: issue rd = 10 -> next cycle busy[10] = 1 and rd_rdy = 0 for ra = 10; writeback 10 = 123456789ABCDEF0 -> busy[10] clears and data reads back.
REQ-038 Scenario, issue/writeback collision: iss_rd = 3 and wa = 3 in the same cycle -> busy[3] remains 1 and reg3 is updated.
REQ-039 Scenario, index 0: write 0 = DEADBEEF and issue 0 -> reads return 0, busy[0] = 0, rd_rdy = 1.
REQ-040 Scenario, asynchronous reset: pulse rst between clock edges with busy nonzero -> busy = 0 and all reads = 0 immediately.
